// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in / serial-out frame transmitter.
// A word offered on load_data/load_valid is captured while the FSM is IDLE and
// sent one bit per clock on ser_out, framed by ser_valid, frame_start and
// frame_end, followed by GAP_CYCLES idle cycles before the next word.
//
// Timing model: the FSM state runs one cycle ahead of the registered serial
// outputs. The state leaves SHIFT on the same edge that loads the last bit
// onto ser_out. As a result:
//   - load_ready is high in the last-bit cycle when GAP_CYCLES is 0, so
//     back-to-back frames stream without a bubble.
//   - In general, load_ready returns WIDTH+GAP_CYCLES-1 cycles after the
//     first-bit cycle, which leaves exactly GAP_CYCLES idle output cycles
//     between frames.

module piso_shift_tx #(
  parameter int   WIDTH      = 8,     // frame length in bits, 2..32
  parameter int   GAP_CYCLES = 1,     // idle cycles after each frame, 0..15
  parameter int   MSB_FIRST  = 1,     // 1: bit WIDTH-1 first, 0: bit 0 first
  parameter logic IDLE_LEVEL = 1'b1   // ser_out level while ser_valid is 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // bit_cnt holds the index of the bit currently on ser_out; the frame ends
  // when the bit after index WIDTH-2 (the last one) is loaded.
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 2);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
  logic             ser_out_next;
  logic             ser_valid_next;
  logic             frame_start_next;
  logic             frame_end_next;

  // Bit-order helpers. The shift register always keeps the bit to be sent
  // next adjacent to the outgoing end, so one shift per edge suffices.
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  // Select the first bit, the following bit and the shifted image for the
  // configured bit order.
  always_comb begin
    if (MSB_FIRST != 0) begin
      first_bit = load_data[WIDTH-1];
      next_bit  = shreg[WIDTH-2];
      shifted   = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      first_bit = load_data[0];
      next_bit  = shreg[1];
      shifted   = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  // Ready and busy are pure state decodes, independent of load_valid.
  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch can be inferred.
    state_next       = state;
    shreg_next       = shreg;
    bit_cnt_next     = bit_cnt;
    gap_cnt_next     = gap_cnt;
    ser_out_next     = IDLE_LEVEL;
    ser_valid_next   = 1'b0;
    frame_start_next = 1'b0;
    frame_end_next   = 1'b0;

    unique case (state)
      IDLE: begin
        // Acceptance: capture the word and present its first bit next cycle.
        if (load_valid) begin
          shreg_next       = load_data;
          bit_cnt_next     = '0;
          ser_out_next     = first_bit;
          ser_valid_next   = 1'b1;
          frame_start_next = 1'b1;
          state_next       = SHIFT;
        end
      end

      SHIFT: begin
        // Load the following bit. Inputs are not looked at here, so traffic
        // on load_valid/load_data cannot disturb the frame in flight.
        shreg_next     = shifted;
        ser_out_next   = next_bit;
        ser_valid_next = 1'b1;
        if (bit_cnt == LAST_SHIFT) begin
          frame_end_next = 1'b1;
          bit_cnt_next   = '0;
          gap_cnt_next   = '0;
          state_next     = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          bit_cnt_next = bit_cnt + CNT_W'(1);
        end
      end

      GAP: begin
        // Hold the line idle for the remaining gap, then reopen for a word.
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and registered serial outputs, with asynchronous reset
  // that aborts any frame and parks the line at IDLE_LEVEL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ser_out     <= IDLE_LEVEL;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values sampled at the same edge, independent of statement order.
      state       <= state_next;
      shreg       <= shreg_next;
      bit_cnt     <= bit_cnt_next;
      gap_cnt     <= gap_cnt_next;
      ser_out     <= ser_out_next;
      ser_valid   <= ser_valid_next;
      frame_start <= frame_start_next;
      frame_end   <= frame_end_next;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: scoreboard bench for piso_shift_tx.
// Five instances with different parameter sets share clk and rst. Every
// accepted word is expanded into its expected per-cycle bits, which are pushed
// into a per-instance queue. A negedge monitor pops these entries and compares
// them with the DUT outputs.

module tb_piso_shift_tx;

  localparam int NDUT = 5;

  // Per-instance parameter sets: defaults, LSB-first, no gap, minimum width
  // with maximum gap, and maximum width.
  function automatic int p_w(input int k);
    case (k)
      3:       return 2;
      4:       return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int p_gap(input int k);
    case (k)
      2:       return 0;
      3:       return 15;
      4:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int p_msb(input int k);
    case (k)
      1, 3, 4: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int p_idle(input int k);
    case (k)
      3, 4:    return 0;
      default: return 1;
    endcase
  endfunction

  typedef struct {
    int   cyc;   // cycle in which this bit must be on ser_out
    logic b;
    logic s;
    logic e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ld_data  [NDUT];
  logic        ld_valid [NDUT];
  logic        rdy [NDUT];
  logic        so  [NDUT];
  logic        sv  [NDUT];
  logic        fs  [NDUT];
  logic        fe  [NDUT];
  logic        bsy [NDUT];

  exp_t q [NDUT][$];
  int   nready [NDUT];   // first cycle in which the instance is ready again
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      piso_shift_tx #(
        .WIDTH      (p_w(g)),
        .GAP_CYCLES (p_gap(g)),
        .MSB_FIRST  (p_msb(g)),
        .IDLE_LEVEL (1'(p_idle(g)))
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .load_data   (ld_data[g][p_w(g)-1:0]),
        .load_valid  (ld_valid[g]),
        .load_ready  (rdy[g]),
        .ser_out     (so[g]),
        .ser_valid   (sv[g]),
        .frame_start (fs[g]),
        .frame_end   (fe[g]),
        .busy        (bsy[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  task automatic check(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h",
               name, d, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle numbering: cycle n is the interval following the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a word offered in cycle n while ready is sent in cycles
  // n+1 .. n+W, and the instance is ready again from cycle n+W+GAP.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    int   idx;
    if (rst) begin
      for (int i = 0; i < NDUT; i++) begin
        q[i].delete();
        nready[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        if (ld_valid[i] && cyc >= nready[i]) begin
          for (int k = 0; k < p_w(i); k++) begin
            idx   = (p_msb(i) != 0) ? p_w(i) - 1 - k : k;
            e.cyc = cyc + 1 + k;
            e.b   = ld_data[i][idx];
            e.s   = (k == 0);
            e.e   = (k == p_w(i) - 1);
            q[i].push_back(e);
          end
          nready[i] <= cyc + p_w(i) + p_gap(i);
        end
      end
    end
  end

  // Monitor: compare outputs with the scoreboard away from the active edge.
  always @(negedge clk) begin
    exp_t me;
    logic mon_rdy;
    for (int i = 0; i < NDUT; i++) begin
      mon_rdy = rst || (cyc >= nready[i]);
      check("load_ready", i, rdy[i], mon_rdy);
      check("busy", i, bsy[i], !mon_rdy);
      if (sv[i]) begin
        if (q[i].size() == 0) begin
          check("unexpected_bit", i, sv[i], 0);
        end else begin
          me = q[i].pop_front();
          check("bit_cycle", i, cyc, me.cyc);
          check("ser_out", i, so[i], me.b);
          check("frame_start", i, fs[i], me.s);
          check("frame_end", i, fe[i], me.e);
        end
      end else begin
        check("idle_ser_out", i, so[i], p_idle(i));
        check("idle_frame_start", i, fs[i], 0);
        check("idle_frame_end", i, fe[i], 0);
        if (q[i].size() > 0 && q[i][0].cyc <= cyc) begin
          check("missing_bit", i, sv[i], 1);
          void'(q[i].pop_front());
        end
      end
    end
  end

  // Stimulus.
  initial begin
    for (int i = 0; i < NDUT; i++) begin
      ld_valid[i] = 1'b0;
      ld_data[i]  = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Quiet line after reset.
    repeat (20) step();

    // First frames: A5 by default, 01 LSB-first, FF then 00 streamed with no gap.
    ld_data[0] = 32'hA5;        ld_valid[0] = 1'b1;
    ld_data[1] = 32'h01;        ld_valid[1] = 1'b1;
    ld_data[2] = 32'hFF;        ld_valid[2] = 1'b1;
    ld_data[3] = 32'h2;         ld_valid[3] = 1'b1;
    ld_data[4] = 32'h8000_0001; ld_valid[4] = 1'b1;
    step();
    ld_valid[0] = 1'b0;
    ld_valid[1] = 1'b0;
    ld_valid[3] = 1'b0;
    ld_valid[4] = 1'b0;
    ld_data[2]  = 32'h00;
    repeat (10) step();
    ld_valid[2] = 1'b0;
    repeat (40) step();

    // C3 frame with a 3C offer pulsed during its fourth bit.
    ld_data[0] = 32'hC3; ld_valid[0] = 1'b1;
    step();
    ld_valid[0] = 1'b0;
    repeat (3) step();
    ld_data[0] = 32'h3C; ld_valid[0] = 1'b1;
    step();
    ld_valid[0] = 1'b0;
    repeat (15) step();

    // F0 frames aborted by an asynchronous reset during the third bit.
    for (int i = 0; i < NDUT; i++) begin
      ld_data[i]  = 32'hF0;
      ld_valid[i] = 1'b1;
    end
    step();
    for (int i = 0; i < NDUT; i++) ld_valid[i] = 1'b0;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("rst_ser_valid", i, sv[i], 0);
      check("rst_ser_out", i, so[i], p_idle(i));
      check("rst_frame_start", i, fs[i], 0);
      check("rst_frame_end", i, fe[i], 0);
      check("rst_busy", i, bsy[i], 0);
      check("rst_load_ready", i, rdy[i], 1);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 81 accepted on the first edge after release.
    for (int i = 0; i < NDUT; i++) begin
      ld_data[i]  = 32'h81;
      ld_valid[i] = 1'b1;
    end
    step();
    for (int i = 0; i < NDUT; i++) ld_valid[i] = 1'b0;
    repeat (40) step();

    // Random traffic.
    repeat (400) begin
      for (int i = 0; i < NDUT; i++) begin
        ld_valid[i] = ($urandom_range(0, 2) == 0);
        ld_data[i]  = $urandom;
      end
      step();
    end
    for (int i = 0; i < NDUT; i++) ld_valid[i] = 1'b0;
    repeat (60) step();

    for (int i = 0; i < NDUT; i++) check("drained", i, q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
